// File: rtl/key_event_ctrl.sv
// key_event_ctrl
// Classifies presses on four debounced, active-low keys as short or long,
// emits one-cycle event pulses and holds the heartbeat user controls.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   key_in[3:0]  in   debounced key levels, 0 = pressed
//   short_pulse  out  one-hot, one-cycle short-press event
//   long_pulse   out  one-hot, one-cycle long-press event
//   mode[1:0]    out  heartbeat pattern select
//   rate[3:0]    out  heartbeat speed setting
//   pause        out  1 = light generator frozen
//   busy         out  1 when the FSM is not idle
module key_event_ctrl #(
    parameter int unsigned LONG_CNT     = 12000000,
    parameter logic [1:0]  MODE_DEFAULT = 2'd0,
    parameter logic [3:0]  RATE_DEFAULT = 4'd4,
    parameter logic [3:0]  RATE_MAX     = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] short_pulse,
    output logic [3:0] long_pulse,
    output logic [1:0] mode,
    output logic [3:0] rate,
    output logic       pause,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(LONG_CNT) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_short;
    logic [3:0]         r_long;
    logic [1:0]         r_mode;
    logic [3:0]         r_rate;
    logic               r_pause;
    logic               r_busy;

    logic               w_all_rel;
    logic [2:0]         w_nzero;
    logic               w_single;
    logic [1:0]         w_idx;
    logic               w_same_key;
    logic               w_cnt_last;

    // Decode the key vector: count pressed keys and locate the pressed one.
    always_comb begin
        w_nzero = 3'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!key_in[i]) begin
                w_nzero = w_nzero + 3'd1;
                w_idx   = 2'(i);
            end
        end
    end

    assign w_all_rel  = (key_in == 4'b1111);
    assign w_single   = (w_nzero == 3'd1);
    assign w_same_key = w_single && (w_idx == r_idx);
    assign w_cnt_last = (r_cnt == CNT_W'(LONG_CNT - 1));

    // Press classifier and user-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_REL;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_short <= 4'd0;
            r_long  <= 4'd0;
            r_mode  <= MODE_DEFAULT;
            r_rate  <= RATE_DEFAULT;
            r_pause <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_short <= 4'd0;
            r_long  <= 4'd0;
            case (r_state)
                IDLE: begin
                    if (w_all_rel) begin
                        r_busy <= 1'b0;
                    end else if (w_single) begin
                        r_state <= HELD;
                        r_idx   <= w_idx;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= WAIT_REL;
                        r_busy  <= 1'b1;
                    end
                end

                HELD: begin
                    if (w_all_rel) begin
                        // Released before the long threshold: short event.
                        r_state        <= IDLE;
                        r_busy         <= 1'b0;
                        r_short[r_idx] <= 1'b1;
                        case (r_idx)
                            2'd0: r_mode <= r_mode + 2'd1;
                            2'd1: if (r_rate < RATE_MAX) r_rate <= r_rate + 4'd1;
                            2'd2: if (r_rate != 4'd0) r_rate <= r_rate - 4'd1;
                            default: r_pause <= ~r_pause;
                        endcase
                    end else if (!w_same_key) begin
                        // Chord or key change mid-press: abort silently.
                        r_state <= WAIT_REL;
                        r_busy  <= 1'b1;
                    end else if (w_cnt_last) begin
                        // Held long enough: long event, then wait for release.
                        r_state       <= WAIT_REL;
                        r_busy        <= 1'b1;
                        r_long[r_idx] <= 1'b1;
                        case (r_idx)
                            2'd0: ;
                            2'd1: r_rate <= RATE_MAX;
                            2'd2: r_rate <= 4'd0;
                            default: begin
                                r_mode  <= MODE_DEFAULT;
                                r_rate  <= RATE_DEFAULT;
                                r_pause <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_busy <= 1'b1;
                    end
                end

                WAIT_REL: begin
                    if (w_all_rel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= WAIT_REL;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign short_pulse = r_short;
    assign long_pulse  = r_long;
    assign mode        = r_mode;
    assign rate        = r_rate;
    assign pause       = r_pause;
    assign busy        = r_busy;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl
// Directed bench for key_event_ctrl with a shortened long-press threshold.
// Expected events are queued when a press is driven and compared when the
// DUT pulses; register state is compared against a small reference model.
module tb_key_event_ctrl;

    localparam int unsigned LONG = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] short_pulse;
    logic [3:0] long_pulse;
    logic [1:0] mode;
    logic [3:0] rate;
    logic       pause;
    logic       busy;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .LONG_CNT     (LONG),
        .MODE_DEFAULT (2'd0),
        .RATE_DEFAULT (4'd4),
        .RATE_MAX     (4'd15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .mode        (mode),
        .rate        (rate),
        .pause       (pause),
        .busy        (busy)
    );

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] l;
        logic [1:0] m;
        logic [3:0] r;
        logic       p;
    } ev_t;

    ev_t        exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       mon_en  = 1'b0;
    logic [1:0] m_mode  = 2'd0;
    logic [3:0] m_rate  = 4'd4;
    logic       m_pause = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the key actions; queues the resulting event.
    task automatic expect_event(input int k, input bit is_long);
        ev_t e;
        e = '0;
        if (is_long) begin
            e.l[k] = 1'b1;
            case (k)
                1: m_rate = 4'd15;
                2: m_rate = 4'd0;
                3: begin m_mode = 2'd0; m_rate = 4'd4; m_pause = 1'b0; end
                default: ;
            endcase
        end else begin
            e.s[k] = 1'b1;
            case (k)
                0: m_mode = m_mode + 2'd1;
                1: if (m_rate != 4'd15) m_rate = m_rate + 4'd1;
                2: if (m_rate != 4'd0) m_rate = m_rate - 4'd1;
                default: m_pause = ~m_pause;
            endcase
        end
        e.m = m_mode;
        e.r = m_rate;
        e.p = m_pause;
        exp_q.push_back(e);
    endtask

    // Hold key k alone for n sampled cycles, then release.
    task automatic press(input int k, input int n);
        logic [3:0] pat;
        pat    = 4'hF;
        pat[k] = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (i == LONG) expect_event(k, 1'b1);
            key_in = pat;
            tick();
        end
        if (n < LONG) expect_event(k, 1'b0);
        key_in = 4'hF;
        tick();
        tick();
    endtask

    task automatic check_regs(input string tag);
        check(tag, {9'd0, mode, rate, pause}, {9'd0, m_mode, m_rate, m_pause});
    endtask

    // Every pulse cycle must match the oldest queued event.
    always @(negedge clk) begin
        if (mon_en && ((short_pulse | long_pulse) !== 4'b0)) begin
            ev_t obs;
            obs = '{short_pulse, long_pulse, mode, rate, pause};
            if (exp_q.size() == 0)
                check("unexpected_pulse", 16'(obs), 16'(0));
            else
                check("event", 16'(obs), 16'(exp_q.pop_front()));
        end
    end

    initial begin
        rst    = 1'b1;
        key_in = 4'b1110;
        tick();
        tick();
        check("reset_pulses", {8'd0, short_pulse, long_pulse}, 16'd0);
        check_regs("reset_regs");
        check("reset_busy", 16'(busy), 16'd1);
        mon_en = 1'b1;

        rst = 1'b0;
        repeat (5) tick();
        check("held_through_reset_busy", 16'(busy), 16'd1);
        key_in = 4'hF;
        tick();
        check("busy_drop", 16'(busy), 16'd0);
        tick();

        // Mode stepping with wrap.
        for (int i = 0; i < 5; i++) begin
            press(0, 3);
            check_regs("mode_step");
        end

        // Rate saturation in both directions.
        repeat (13) press(1, 2);
        check_regs("rate_sat_hi");
        repeat (20) press(2, 2);
        check_regs("rate_sat_lo");

        // Long vs short boundary on key3.
        press(3, LONG - 1);
        check_regs("key3_short_pause");
        press(3, LONG);
        check_regs("key3_long_restore");

        // Remaining long actions and one-cycle press.
        press(1, LONG + 2);
        check_regs("key1_long");
        press(0, LONG + 1);
        check_regs("key0_long");
        press(2, LONG);
        check_regs("key2_long");
        press(1, 1);
        check_regs("one_cycle_press");

        // Chord from idle.
        key_in = 4'b1100;
        repeat (5) begin
            tick();
            check("chord_busy", 16'(busy), 16'd1);
        end
        key_in = 4'hF;
        tick();
        check("chord_release_busy", 16'(busy), 16'd0);

        // Abort mid-press.
        key_in = 4'b1110;
        tick();
        tick();
        key_in = 4'b1100;
        tick();
        key_in = 4'hF;
        tick();
        tick();
        check_regs("abort_regs");

        // Reset while a key is held.
        key_in = 4'b1101;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        m_mode  = 2'd0;
        m_rate  = 4'd4;
        m_pause = 1'b0;
        repeat (10) tick();
        check("reset_hold_busy", 16'(busy), 16'd1);
        key_in = 4'hF;
        tick();
        tick();
        check_regs("reset_mid_hold");

        repeat (4) tick();
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
